aes_sub_bytes_iter: RTL
=======================

# aes_sub_bytes_iter

Parametrised, multi-cycle SubBytes unit for the iterative AES datapath. It accepts a full 128-bit state over a valid/ready handshake and substitutes LANES bytes per cycle through forward or inverse S-boxes. It returns the substituted state over a second valid/ready handshake. It sits between AddRoundKey and ShiftRows and lets area and throughput be traded by choosing the lane count.

## Interface
Parameters:
- LANES, 4, S-box instances (bytes per cycle); legal values 1, 2, 4, 8, 16; any other value is a fatal elaboration error.
- REG_OUT, 1, 1 inserts a register between S-box output and state writeback (adds one cycle); 0 writes back combinationally.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk  in  1  clock; all state updates on the rising edge.
  - rst_n  in  1  asynchronous active-low reset.
- Input handshake:
  - in_valid  in  1  input state valid.
  - in_ready  out  1  unit can accept a state.
  - in_state  in  128  input state.
  - in_inv  in  1  mode select: 0 = forward S-box, 1 = inverse S-box; sampled at accept.
- Output handshake:
  - out_valid  out  1  out_state holds a complete result.
  - out_ready  in  1  downstream accepts the result.
  - out_state  out  128  substituted state.
- Status:
  - busy  out  1  high in SUB and DONE.

## Operation
- Byte order is FIPS-197: byte i is in_state[127-8i -: 8], so byte 0 is the MSB.
- N = 16/LANES chunks. Chunk k covers bytes LANES*k .. LANES*k+LANES-1.
- IDLE:
  - in_ready=1.
  - On in_valid: latch in_state into the working register, latch in_inv into mode_q, clear the chunk counter, then go to SUB.
- SUB:
  - Each cycle, chunk k is read from the working register, passed through LANES S-boxes using mode_q, and written back in place.
  - With REG_OUT=1, the read in cycle k writes back in cycle k+1, so reads and writebacks are pipelined.
  - After the last writeback, go to DONE.
- DONE:
  - out_valid=1, and out_state is the working register.
  - out_state and out_valid stay stable until out_ready.
  - On out_ready without in_valid: go to IDLE.
  - On out_ready with in_valid in the same cycle: accept the new state and go straight to SUB. In DONE, in_ready = out_ready, which gives back-to-back operation.
- in_ready is 0 in SUB. in_state and in_inv are ignored outside an accept.
- Counter width is max(1, $clog2(N)). The counter does not wrap; leaving SUB happens on the terminal count.
- LANES=16, REG_OUT=0: SUB lasts exactly one cycle.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, out_state=128'h0. Internal state: IDLE, counter 0, mode_q 0.
- Latency from the accept edge to the edge where out_valid rises is N+REG_OUT cycles.
  - LANES=4, REG_OUT=1: 5 cycles.
  - LANES=1, REG_OUT=0: 16 cycles.
  - LANES=16, REG_OUT=0: 1 cycle.
- Throughput with out_ready held at 1 is one state every N+REG_OUT+1 cycles (the DONE cycle also accepts the next state).
- rst_n asserted mid-operation:
  - All state returns to reset values immediately; the partial result is discarded.
  - After release, the first accept produces a clean result.
- Changing in_inv mid-operation has no effect.

## Structure
- Package aes_pkg holds:
  - `const logic [7:0] SBOX[256]` and `INV_SBOX[256]`.
  - `typedef logic [127:0] aes_state_t`.
  - `typedef enum logic [1:0] {IDLE, SUB, DONE} sub_state_e`.
- Sub-module aes_sbox is an 8-bit combinational lookup (in, inv, out) that indexes SBOX or INV_SBOX. It is instantiated LANES times via generate.

## Test plan
- Forward FIPS vector: LANES=4, REG_OUT=1, accept in_state=193de3bea0f4e22b9ac68d2ae9f84808, in_inv=0 -> after 5 cycles out_state=d42711aee0bf98f1b8b45de51e415230, and busy is high throughout.
- Inverse round trip: LANES=2, REG_OUT=0, in_inv=1, in_state=d42711aee0bf98f1b8b45de51e415230 -> out_state=193de3bea0f4e22b9ac68d2ae9f84808 after 8 cycles.
- Full table sweep: for all LANES values, a state of 16 identical bytes b for every b in 00..FF, both modes -> spot values S(00)=63, S(53)=ED, InvS(63)=00, InvS(ED)=53, and every byte checked against a reference model.
- Backpressure:
  - out_ready held 0 for 10 cycles after out_valid -> out_state is stable and in_ready=0.
  - Then out_ready=1 with in_valid=1 in the same cycle -> the new state is accepted that edge, with no idle cycle.
- Reset mid-operation: LANES=1, rst_n pulsed low at cycle 7 of SUB -> outputs immediately return to reset values. A subsequent all-00 input gives out_state=16 bytes of 63.
- Mode isolation: in_inv toggled and in_state changed every cycle during SUB -> the result matches the mode and state sampled at accept.

Source files
------------

// File: rtl/aes_pkg.sv
// AES SubBytes support package: S-box tables, state type, iteration FSM states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package aes_pkg;

    typedef logic [127:0] aes_state_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } sub_state_e;

    const logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    const logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

endpackage

// File: rtl/aes_sbox.sv
// Single-byte AES S-box lookup, forward (inv=0) or inverse (inv=1).
// Latency: combinational.
// Backpressure: none (pure function).
// Ports: in = byte to substitute, inv = direction select, out = substituted byte.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] in,
    input  logic       inv,
    output logic [7:0] out
);

    assign out = inv ? INV_SBOX[in] : SBOX[in];

endmodule

// File: rtl/aes_sub_bytes_iter.sv
// Iterative AES SubBytes: LANES bytes per cycle over a 128-bit working register.
// Latency: 16/LANES + REG_OUT cycles from accept edge to out_valid rising edge.
// Backpressure: result held in DONE until out_ready; in_ready=0 while substituting.
// Ports: clk/rst_n (async active-low); in_valid/in_ready/in_state/in_inv accept a
// state and mode; out_valid/out_ready/out_state return it; busy is high in SUB/DONE.
module aes_sub_bytes_iter
    import aes_pkg::*;
#(
    parameter int LANES   = 4,
    parameter int REG_OUT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  aes_state_t in_state,
    input  logic       in_inv,
    output logic       out_valid,
    input  logic       out_ready,
    output aes_state_t out_state,
    output logic       busy
);

    localparam int N  = 16 / LANES;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int CB = 8 * LANES;             // chunk width in bits
    localparam logic [CW-1:0] LAST = CW'(N - 1);
    // Mask covering the most significant chunk (byte 0 side) of the state.
    localparam aes_state_t TOP_MASK = ~(aes_state_t'('1) >> CB);

    generate
        if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
            $fatal(1, "aes_sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    sub_state_e    state_q, state_d;
    aes_state_t    work_q;
    logic          mode_q;
    logic [CW-1:0] cnt_q;
    logic          rd_done_q;   // all chunks have been read (pipelined writeback only)

    logic          accept;
    logic          rd_en;
    logic          sub_last;
    logic          wr_en;
    logic [CW-1:0] wr_idx;
    logic [CB-1:0] wr_dat;
    logic [CB-1:0] rd_chunk;
    logic [CB-1:0] sb_chunk;
    aes_state_t    rd_shift;
    aes_state_t    wr_mask;
    aes_state_t    wr_ins;

    assign accept = in_valid && in_ready;
    assign rd_en  = (state_q == SUB) && !rd_done_q;

    // Chunk k starts at byte LANES*k counted from the MSB, so shift it to the top.
    assign rd_shift = work_q << (CB * cnt_q);
    assign rd_chunk = rd_shift[127 -: CB];

    genvar i;
    generate
        for (i = 0; i < LANES; i++) begin : g_lane
            aes_sbox u_sbox (
                .in  (rd_chunk[CB-1-8*i -: 8]),
                .inv (mode_q),
                .out (sb_chunk[CB-1-8*i -: 8])
            );
        end

        if (REG_OUT != 0) begin : g_reg_out
            logic          wb_vld_q;
            logic [CW-1:0] wb_idx_q;
            logic [CB-1:0] wb_dat_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    wb_vld_q <= 1'b0;
                    wb_idx_q <= '0;
                    wb_dat_q <= '0;
                end else begin
                    wb_vld_q <= rd_en;
                    wb_idx_q <= cnt_q;
                    wb_dat_q <= sb_chunk;
                end
            end

            assign wr_en    = wb_vld_q && (state_q == SUB);
            assign wr_idx   = wb_idx_q;
            assign wr_dat   = wb_dat_q;
            // The cycle after the final read carries the final writeback.
            assign sub_last = rd_done_q;
        end else begin : g_comb_out
            assign wr_en    = rd_en;
            assign wr_idx   = cnt_q;
            assign wr_dat   = sb_chunk;
            assign sub_last = (cnt_q == LAST);
        end
    endgenerate

    assign wr_mask = TOP_MASK >> (CB * wr_idx);
    assign wr_ins  = (aes_state_t'(wr_dat) << (128 - CB)) >> (CB * wr_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = SUB;
            end
            SUB: begin
                busy = 1'b1;
                if (sub_last) state_d = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                // Handing off the result frees the register for a same-cycle accept.
                in_ready  = out_ready;
                if (out_ready) state_d = in_valid ? SUB : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_q    <= '0;
            mode_q    <= 1'b0;
            cnt_q     <= '0;
            rd_done_q <= 1'b0;
        end else if (accept) begin
            work_q    <= in_state;
            mode_q    <= in_inv;
            cnt_q     <= '0;
            rd_done_q <= 1'b0;
        end else begin
            if (wr_en) begin
                work_q <= (work_q & ~wr_mask) | wr_ins;
            end
            // Counter parks at the terminal count rather than wrapping.
            if (rd_en) begin
                if (cnt_q == LAST) begin
                    if (REG_OUT != 0) rd_done_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    assign out_state = work_q;

endmodule
